// File: rtl/nextasic_pkg.sv
// Shared definitions for the monitor TX path: FSM encoding, grant_id codes and packet width.
package nextasic_pkg;

   localparam int PKT_W = 40;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_GAP       = 2'd3
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PWR  = 2'd1,
      GNT_AUD  = 2'd2,
      GNT_KBD  = 2'd3
   } grant_t;

   // pwr always wins; aud/kbd ties are broken by the round-robin pointer
   function automatic grant_t pick_winner(input logic pwr, input logic aud,
                                          input logic kbd, input logic rr_kbd);
      grant_t g;
      g = GNT_NONE;
      if (pwr)
         g = GNT_PWR;
      else if (aud && kbd)
         g = rr_kbd ? GNT_KBD : GNT_AUD;
      else if (aud)
         g = GNT_AUD;
      else if (kbd)
         g = GNT_KBD;
      return g;
   endfunction

endpackage

// File: rtl/mon_tx_timer.sv
// Loadable saturating down-counter shared by the gap and tx_done-timeout phases.
// Load wins over decrement; the count holds at zero instead of wrapping.
module mon_tx_timer #(
   parameter int CNT_W = 12
) (
   input  logic             mon_clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge mon_clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (dec && !zero)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mon_tx_arbiter.sv
// Arbitrates pwr/aud/kbd packets onto one serial sender; out_valid and ack follow a sampled request by one cycle.
// One packet in flight: new requests wait for tx_done (or timeout) plus GAP quiet cycles.
module mon_tx_arbiter
   import nextasic_pkg::*;
#(
   parameter int GAP     = 8,
   parameter int TIMEOUT = 4095,
   parameter int CNT_W   = 12
) (
   input  logic             mon_clk,
   input  logic             rst_n,
   input  logic             pwr_req,
   input  logic             aud_req,
   input  logic             kbd_req,
   input  logic [PKT_W-1:0] pwr_data,
   input  logic [PKT_W-1:0] aud_data,
   input  logic [PKT_W-1:0] kbd_data,
   output logic             pwr_ack,
   output logic             aud_ack,
   output logic             kbd_ack,
   output logic [PKT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             tx_done,
   output logic [1:0]       grant_id,
   output logic             busy,
   output logic             err_timeout
);

   localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   arb_state_t       state;
   logic             rr_kbd;
   grant_t           winner;
   logic [PKT_W-1:0] win_data;
   logic             tmr_load;
   logic             tmr_dec;
   logic             tmr_zero;
   logic             tmr_last;
   logic             wait_end;
   logic [CNT_W-1:0] tmr_load_val;
   logic [CNT_W-1:0] tmr_cnt;

   mon_tx_timer #(.CNT_W(CNT_W)) u_timer (
      .mon_clk  (mon_clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .dec      (tmr_dec),
      .cnt      (tmr_cnt),
      .zero     (tmr_zero)
   );

   // A phase loaded with N lasts exactly N cycles: leave when the count is on its last step.
   assign tmr_last = tmr_zero || (tmr_cnt == CNT_ONE);
   assign wait_end = (state == ST_WAIT_DONE) && (tx_done || tmr_last);

   always_comb begin
      winner = pick_winner(pwr_req, aud_req, kbd_req, rr_kbd);
      case (winner)
         GNT_AUD: win_data = aud_data;
         GNT_KBD: win_data = kbd_data;
         default: win_data = pwr_data;
      endcase
   end

   always_comb begin
      tmr_load     = 1'b0;
      tmr_load_val = GAP_LOAD;
      tmr_dec      = 1'b0;
      case (state)
         ST_ISSUE: begin
            tmr_load     = 1'b1;
            tmr_load_val = TIMEOUT_LOAD;
         end
         ST_WAIT_DONE: begin
            if (wait_end)
               tmr_load = 1'b1;
            else
               tmr_dec = 1'b1;
         end
         ST_GAP:  tmr_dec = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge mon_clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         rr_kbd      <= 1'b0;
         out_valid   <= 1'b0;
         pwr_ack     <= 1'b0;
         aud_ack     <= 1'b0;
         kbd_ack     <= 1'b0;
         out_data    <= '0;
         grant_id    <= GNT_NONE;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         pwr_ack   <= 1'b0;
         aud_ack   <= 1'b0;
         kbd_ack   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (winner != GNT_NONE) begin
                  state     <= ST_ISSUE;
                  out_valid <= 1'b1;
                  out_data  <= win_data;
                  grant_id  <= winner;
                  busy      <= 1'b1;
                  pwr_ack   <= (winner == GNT_PWR);
                  aud_ack   <= (winner == GNT_AUD);
                  kbd_ack   <= (winner == GNT_KBD);
                  if (winner != GNT_PWR)
                     rr_kbd <= (winner == GNT_AUD);
               end
            end
            ST_ISSUE: state <= ST_WAIT_DONE;
            ST_WAIT_DONE: begin
               if (wait_end) begin
                  if (!tx_done)
                     err_timeout <= 1'b1;
                  if (GAP == 0) begin
                     state    <= ST_IDLE;
                     grant_id <= GNT_NONE;
                     busy     <= 1'b0;
                  end else begin
                     state <= ST_GAP;
                  end
               end
            end
            ST_GAP: begin
               if (tmr_last) begin
                  state    <= ST_IDLE;
                  grant_id <= GNT_NONE;
                  busy     <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
